// File: rtl/instr_loader.sv
// instr_loader: program-load sequencer between the UART word receiver and the
// instruction memory. Parses a SYNC header, writes N words to consecutive
// addresses, and holds the CPU in reset until the load completes.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing 16-bit
// wrap-around sum of the data words before releasing the CPU.
module instr_loader #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [7:0]  SYNC         = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_dv,
  input  logic [15:0]           i_rx_instr,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_data,
  output logic                  o_cpu_rst,
  output logic                  o_load_done,
  output logic                  o_load_err,
  output logic                  o_busy
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0] MAX_WORDS  = 9'(1 << ADDR_WIDTH);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_ERR} state_t;
`endif

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]              rem_q, rem_d;      // data words still expected, minus one
  logic [TW-1:0]           timer_q, timer_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]             mem_data_q, mem_data_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]             sum_q, sum_d;
`endif

  logic       is_hdr;
  logic [8:0] hdr_words;

  assign is_hdr    = (i_rx_instr[15:8] == SYNC);
  assign hdr_words = {1'b0, i_rx_instr[7:0]} + 9'd1;

  // State register and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wr_addr_q  <= '0;
      rem_q      <= '0;
      timer_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rem_q      <= rem_d;
      timer_q    <= timer_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state, write strobe and timeout logic; flags are decoded from the
  // next state so they change together with the state register.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rem_d      = rem_q;
    timer_d    = '0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (i_rx_dv) begin
          mem_we_d   = 1'b1;
          mem_addr_d = wr_addr_q;
          mem_data_d = i_rx_instr;
          wr_addr_d  = wr_addr_q + 1'b1;
          rem_d      = rem_q - 8'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = sum_q + i_rx_instr;
          if (rem_q == 8'd0) state_d = S_CHECK;
`else
          if (rem_q == 8'd0) state_d = S_RUN;
`endif
        end else if (timer_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (i_rx_dv) begin
          state_d = (i_rx_instr == sum_q) ? S_RUN : S_ERR;
        end else if (timer_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      default: begin
        if (i_rx_dv && is_hdr) begin
          if (hdr_words > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d   = S_LOAD;
            wr_addr_d = '0;
            rem_d     = i_rx_instr[7:0];
`ifdef LOADER_CHECKSUM_EN
            sum_d     = '0;
`endif
          end
        end
      end
    endcase

    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
`ifdef LOADER_CHECKSUM_EN
    busy_d    = (state_d == S_LOAD) || (state_d == S_CHECK);
`else
    busy_d    = (state_d == S_LOAD);
`endif
  end

  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_data  = mem_data_q;
  assign o_cpu_rst   = cpu_rst_q;
  assign o_load_done = done_q;
  assign o_load_err  = err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: a phase-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_instr_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 1000;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_rx_dv;
  logic [15:0]   i_rx_instr;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [15:0]   o_mem_data;
  logic          o_cpu_rst;
  logic          o_load_done;
  logic          o_load_err;
  logic          o_busy;

  int checks = 0;
  int errors = 0;

  instr_loader #(.ADDR_WIDTH(AW), .SYNC(8'hA5), .TIMEOUT_CLKS(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_dv(i_rx_dv), .i_rx_instr(i_rx_instr),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_cpu_rst(o_cpu_rst), .o_load_done(o_load_done), .o_load_err(o_load_err),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase name, words left, next address, running sum and
  // clocks since the last accepted word.
  string       m_phase;
  int          m_left, m_next, m_idle;
  logic [15:0] m_sum;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_data;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_phase = "IDLE"; m_left = 0; m_next = 0; m_idle = 0;
      m_sum = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = 0;
      if (m_phase == "LOAD" || m_phase == "CHECK") begin
        if (i_rx_dv) begin
          m_idle = 0;
          if (m_phase == "LOAD") begin
            m_we = 1; m_addr = 16'(m_next); m_data = i_rx_instr;
            m_next++; m_sum = m_sum + i_rx_instr; m_left--;
            if (m_left == 0) begin
`ifdef LOADER_CHECKSUM_EN
              m_phase = "CHECK";
`else
              m_phase = "RUN";
`endif
            end
          end else if (i_rx_instr == m_sum) m_phase = "RUN";
          else m_phase = "ERR";
        end else begin
          m_idle++;
          if (m_idle >= int'(TO)) m_phase = "ERR";
        end
      end else if (i_rx_dv && i_rx_instr[15:8] == 8'hA5) begin
        if (int'(i_rx_instr[7:0]) + 1 > (1 << AW)) m_phase = "ERR";
        else begin
          m_phase = "LOAD"; m_left = int'(i_rx_instr[7:0]) + 1;
          m_next = 0; m_sum = 0; m_idle = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    chk("we",      {31'b0, o_mem_we},    {31'b0, m_we});
    chk("addr",    {28'b0, o_mem_addr},  {16'b0, m_addr});
    chk("data",    {16'b0, o_mem_data},  {16'b0, m_data});
    chk("cpu_rst", {31'b0, o_cpu_rst},   {31'b0, (m_phase != "RUN")});
    chk("done",    {31'b0, o_load_done}, {31'b0, (m_phase == "RUN")});
    chk("err",     {31'b0, o_load_err},  {31'b0, (m_phase == "ERR")});
    chk("busy",    {31'b0, o_busy},      {31'b0, (m_phase == "LOAD" || m_phase == "CHECK")});
  end

  logic [AW-1:0] wl_addr[$];
  logic [15:0]   wl_data[$];
  always @(negedge i_clk) if (o_mem_we === 1'b1) begin
    wl_addr.push_back(o_mem_addr);
    wl_data.push_back(o_mem_data);
  end

  // Call at a falling edge; the word is sampled on the next rising edge.
  task automatic send(input logic [15:0] w, input int gap);
    i_rx_dv = 1'b1; i_rx_instr = w;
    @(negedge i_clk);
    i_rx_dv = 1'b0; i_rx_instr = 16'h0;
    repeat (gap) @(negedge i_clk);
  endtask

  task automatic load(input logic [7:0] cnt, input logic [15:0] a, b, c, input int gap);
    logic [15:0] s;
    logic [15:0] w;
    s = 16'h0;
    send({8'hA5, cnt}, gap);
    for (int i = 0; i <= int'(cnt); i++) begin
      w = (i == 0) ? a : (i == 1) ? b : c;
      send(w, gap);
      s = s + w;
    end
`ifdef LOADER_CHECKSUM_EN
    send(s, gap);
`endif
  endtask

  int b;
  int lat;
  logic [15:0] s16;

  initial begin
    i_rst = 1'b1; i_rx_dv = 1'b0; i_rx_instr = 16'h0;
    repeat (2) @(negedge i_clk);
    chk("rst_outputs", {o_mem_we, 12'(o_mem_addr), o_mem_data, o_cpu_rst, o_load_done, o_load_err, o_busy},
        {1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    i_rst = 1'b0;
    @(negedge i_clk);

    // Normal load of three words.
    b = wl_addr.size();
`ifdef LOADER_CHECKSUM_EN
    load(8'h02, 16'h1111, 16'h2222, 16'h3333, 1);
`else
    send(16'hA502, 1); send(16'h1111, 1); send(16'h2222, 1); send(16'h3333, 0);
    chk("last_strobe_with_run", {30'b0, o_mem_we, o_cpu_rst}, 32'h2);
`endif
    repeat (2) @(negedge i_clk);
    chk("normal_nwrites", wl_addr.size() - b, 3);
    chk("normal_w0", {12'(wl_addr[b]),   wl_data[b]},   {12'h0, 16'h1111});
    chk("normal_w1", {12'(wl_addr[b+1]), wl_data[b+1]}, {12'h1, 16'h2222});
    chk("normal_w2", {12'(wl_addr[b+2]), wl_data[b+2]}, {12'h2, 16'h3333});
    chk("normal_run", {30'b0, o_load_done, o_cpu_rst}, 32'h2);

    // Non-header word in RUN is ignored; header restarts a load.
    b = wl_addr.size();
    send(16'h1234, 3);
    chk("ignore_nowrite", wl_addr.size() - b, 0);
    chk("ignore_done", {31'b0, o_load_done}, 32'h1);
    send(16'hA500, 0);
    chk("reload_flags", {29'b0, o_cpu_rst, o_busy, o_load_done}, 32'h6);
    chk("reload_hdr_nowrite", wl_addr.size() - b, 0);
    send(16'h0042, 1);
`ifdef LOADER_CHECKSUM_EN
    send(16'h0042, 1);
`endif
    chk("reload_w", {12'(wl_addr[b]), wl_data[b]}, {12'h0, 16'h0042});
    chk("reload_done", {31'b0, o_load_done}, 32'h1);

    // Oversize header: N = 17 with 16 addresses.
    b = wl_addr.size();
    send(16'hA510, 2);
    chk("oversize_err", {30'b0, o_load_err, o_cpu_rst}, 32'h3);
    chk("oversize_nowrite", wl_addr.size() - b, 0);

    // Largest legal load: N = 16, back-to-back words.
    b = wl_addr.size();
    s16 = 16'h0;
    send(16'hA50F, 0);
    for (int i = 0; i < 16; i++) begin
      send(16'(i * 16'h1001), 0);
      s16 = s16 + 16'(i * 16'h1001);
    end
`ifdef LOADER_CHECKSUM_EN
    send(s16, 0);
`endif
    @(negedge i_clk);
    chk("full_nwrites", wl_addr.size() - b, 16);
    chk("full_last", {12'(wl_addr[b+15]), wl_data[b+15]}, {12'hF, 16'hF00F});
    chk("full_done", {31'b0, o_load_done}, 32'h1);

    // Timeout after one data word.
    send(16'hA503, 2);
    send(16'h0777, 0);
    lat = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge i_clk);
      if (o_load_err) begin lat = i; break; end
    end
    chk("timeout_latency", lat, 1000);
    b = wl_addr.size();
    load(8'h00, 16'h0042, 16'h0, 16'h0, 1);
    chk("after_timeout_w", {12'(wl_addr[b]), wl_data[b]}, {12'h0, 16'h0042});
    chk("after_timeout_done", {31'b0, o_load_done}, 32'h1);

    // Word arriving on the very clock the timeout would fire.
    send(16'hA501, 0);
    repeat (999) @(negedge i_clk);
    send(16'hAAAA, 0);
    chk("dv_beats_timeout", {30'b0, o_load_err, o_busy}, 32'h1);
    send(16'hBBBB, 0);
`ifdef LOADER_CHECKSUM_EN
    send(16'h6665, 0);
`endif
    @(negedge i_clk);
    chk("dv_beats_timeout_done", {31'b0, o_load_done}, 32'h1);

    // Header-shaped word during LOAD is stored as data.
    b = wl_addr.size();
    load(8'h01, 16'hA5FF, 16'h0001, 16'h0, 0);
    @(negedge i_clk);
    chk("hdr_as_data", {12'(wl_addr[b]), wl_data[b]}, {12'h0, 16'hA5FF});
    chk("hdr_as_data_done", {31'b0, o_load_done}, 32'h1);

`ifdef LOADER_CHECKSUM_EN
    send(16'hA501, 1); send(16'h8000, 1); send(16'h8001, 1); send(16'h0001, 1);
    chk("csum_ok", {30'b0, o_load_done, o_cpu_rst}, 32'h2);
    send(16'hA501, 1); send(16'h8000, 1); send(16'h8001, 1); send(16'h0002, 1);
    chk("csum_bad", {30'b0, o_load_err, o_cpu_rst}, 32'h3);
`endif

    // Asynchronous reset mid-load.
    send(16'hA503, 1); send(16'h0101, 1); send(16'h0202, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst", {o_mem_we, 12'(o_mem_addr), o_mem_data, o_cpu_rst, o_load_done, o_load_err, o_busy},
        {1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    b = wl_addr.size();
    load(8'h01, 16'h0BAD, 16'h0CAD, 16'h0, 1);
    chk("post_rst_w1", {12'(wl_addr[b+1]), wl_data[b+1]}, {12'h1, 16'h0CAD});
    chk("post_rst_done", {31'b0, o_load_done}, 32'h1);

    repeat (3) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program-load sequencer sitting between the two-byte UART instruction receiver and the processor's instruction memory. It consumes 16-bit words from the receiver's `o_rx_instr`/`o_rx_dv` stream, parses a header, writes the following words to consecutive memory addresses and holds the CPU in reset until the load completes. It also handles framing errors, inter-word timeouts and reload requests.

## Interface
- `ADDR_WIDTH`, 8: instruction memory address width; must be ≤ 8.
- `SYNC`, 8'hA5: header marker expected in header bits [15:8].
- `TIMEOUT_CLKS`, 100000: maximum clocks allowed between words during a load.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; one clock, asynchronous and active-high.
- `i_rx_dv`  in  1  one-cycle pulse, `i_rx_instr` valid.
- `i_rx_instr`  in  16  received word.
- `o_mem_we`  out  1  one-cycle memory write strobe.
- `o_mem_addr`  out  ADDR_WIDTH  write address.
- `o_mem_data`  out  16  write data.
- `o_cpu_rst`  out  1  CPU reset request, high while not running.
- `o_load_done`  out  1  level; last load succeeded and CPU is running.
- `o_load_err`  out  1  level; last load failed.
- `o_busy`  out  1  level; load in progress.

## Operation
- States: IDLE, LOAD, CHECK (present only with `LOADER_CHECKSUM_EN`), RUN, ERR.
- A header is a word with [15:8] == `SYNC`. Word count N = header[7:0] + 1, giving a range of 1..256.
- Header accepted in IDLE, RUN or ERR:
  - If N > 2^ADDR_WIDTH, go to ERR.
  - Otherwise clear the address and word counter, clear done/err, and go to LOAD.
- A non-header word in IDLE, RUN or ERR is ignored.
- LOAD, on each `i_rx_dv`:
  - Write the word at the current address, then increment the address.
  - Header parsing is disabled, so a word equal to a header is stored as data.
  - After the Nth write, go to CHECK (macro defined) or RUN (macro undefined).
- CHECK: the next word is compared with the 16-bit wrap-around sum of the N data words. This word is not written.
  - Match: go to RUN.
  - Mismatch: go to ERR.
- RUN: `o_cpu_rst`=0, `o_load_done`=1.
- ERR: `o_load_err`=1, `o_cpu_rst`=1. ERR is left only by a valid header.
- Timeout: in LOAD/CHECK a counter counts clocks since the last accepted word (the header counts as a word).
  - When the counter reaches `TIMEOUT_CLKS`, go to ERR.
  - The counter is cleared on every `i_rx_dv`.
- `o_busy` = 1 in LOAD and CHECK.
- `o_cpu_rst` = 1 in every state except RUN.

## Timing
- Reset values: `o_mem_we`=0, `o_mem_addr`=0, `o_mem_data`=0, `o_cpu_rst`=1, `o_load_done`=0, `o_load_err`=0, `o_busy`=0, state=IDLE, counters=0.
- All outputs are registered.
- Write latency: a word pulsed at cycle t gives `o_mem_we`=1 with valid addr/data at cycle t+1, for exactly one cycle.
- State and flags change in the cycle after the triggering `i_rx_dv`.
  - After the last write, or after the checksum word, `o_cpu_rst` falls 1 cycle later, in the same cycle as the last write strobe (no-checksum case).
- Header received in RUN:
  - `o_cpu_rst` rises and `o_load_done` falls on the next cycle.
  - No memory write occurs for the header.
- Simultaneous `i_rx_dv` and timeout expiry in the same cycle: `i_rx_dv` wins; the word is accepted and the counter cleared.
- Address wrap: cannot occur, because N ≤ 2^ADDR_WIDTH is enforced at the header.
- `i_rst` mid-load: outputs return to reset values immediately and asynchronously. Partially written memory is left as is.
- `i_rx_dv` is never asserted on consecutive cycles by the receiver. The loader must still accept back-to-back pulses at one word per cycle.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - CHECK state and 16-bit sum accumulator are present.
  - A trailing checksum word is required after the N data words.
- Undefined:
  - No CHECK state or accumulator.
  - The load completes into RUN directly after the Nth write.

## Test plan
- Normal load, macro undefined: send 16'hA502, 16'h1111, 16'h2222, 16'h3333 → writes at addresses 0/1/2 with those values; `o_cpu_rst` falls after the third write; `o_load_done`=1.
- Checksum, macro defined, `TIMEOUT_CLKS`=1000:
  - 16'hA501, 16'h8000, 16'h8001, 16'h0001 → RUN.
  - Repeat with last word 16'h0002 → ERR, `o_load_err`=1, `o_cpu_rst`=1.
- Oversize, `ADDR_WIDTH`=4: header 16'hA510 (N=17) → ERR, no writes.
- Timeout, `TIMEOUT_CLKS`=1000: header 16'hA503, one data word, then silence → ERR exactly 1000 clocks after the data word's `i_rx_dv`. Then send 16'hA500, 16'h0042 → RUN, addr 0 = 16'h0042.
- Reload and ignore: in RUN, send 16'h1234 → no change. Then send 16'hA500 → `o_cpu_rst`=1 and `o_busy`=1 next cycle.
- Async reset: assert `i_rst` mid-load, between clock edges → all outputs at reset values without waiting for a clock edge; a fresh header then loads normally.
